instruction_reader: RTL and testbench

INSTRUCTION_READER -- requirements
Module: instruction_reader

---
 rtl/instruction_reader_if.sv | 28 ++
 rtl/instruction_reader.sv | 130 +++++++++++++
 tb/tb_instruction_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_reader_if.sv
// Memory read port plus instruction handshake of instruction_reader.
// The master modport is the reader; the slave side is memory and consumer.
interface instruction_reader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_address;
  logic [CNT_W-1:0]  instr_count;
  logic [ADDR_W-1:0] direct_read_address;
  logic [7:0]        direct_read_data;
  logic [11:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, start_address, instr_count, direct_read_data, instr_ready,
    output direct_read_address, instr, instr_valid, busy, done, err
  );

  modport slave (
    output start, start_address, instr_count, direct_read_data, instr_ready,
    input  direct_read_address, instr, instr_valid, busy, done, err
  );
endinterface

// File: rtl/instruction_reader.sv
// Reads packed 1/2-byte instructions from memory and hands them out over a valid/ready port.
// Define INSTR_READER_FORMAT_CHECK_EN to flag opcode bytes with a nonzero low nibble on err.
module instruction_reader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  instruction_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, OP_ADDR, OP_CAP, ARG_ADDR, ARG_CAP, OUT, FIN
  } state_e;

  // Opcodes below this value carry one operand byte.
  localparam logic [3:0] ARG_OP_LIMIT = 4'd3;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [11:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              fmt_bad;

`ifdef INSTR_READER_FORMAT_CHECK_EN
  logic err_q, err_d;

  assign fmt_bad = (state_q == OP_CAP) && (bus.direct_read_data[3:0] != 4'h0);

  // Sticky format error, cleared by any accepted start.
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && bus.start) err_d = 1'b0;
    if (fmt_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign fmt_bad = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    accept  = (state_q == OUT) && valid_q && bus.instr_ready;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.instr_count != '0) begin
            ptr_d   = bus.start_address;
            cnt_d   = bus.instr_count;
            state_d = OP_ADDR;
          end else begin
            state_d = FIN;
          end
        end
      end
      OP_ADDR: state_d = OP_CAP;
      OP_CAP: begin
        ptr_d   = ptr_q + ADDR_W'(1);
        instr_d = {bus.direct_read_data[7:4], 8'h00};
        if (fmt_bad)                                       state_d = FIN;
        else if (bus.direct_read_data[7:4] < ARG_OP_LIMIT) state_d = ARG_ADDR;
        else                                               state_d = OUT;
      end
      ARG_ADDR: state_d = ARG_CAP;
      ARG_CAP: begin
        ptr_d        = ptr_q + ADDR_W'(1);
        instr_d[7:0] = bus.direct_read_data;
        state_d      = OUT;
      end
      OUT: begin
        // valid rises one cycle after entering OUT and holds until accepted.
        if (accept) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? FIN : OP_ADDR;
        end else begin
          valid_d = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.direct_read_address = ptr_q;
  assign bus.instr               = instr_q;
  assign bus.instr_valid         = valid_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;

endmodule

// File: tb/tb_instruction_reader.sv
// Directed bench for instruction_reader with a synchronous-read memory model.
module tb_instruction_reader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  instruction_reader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  instruction_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  logic [7:0] mem [256];
  always @(posedge clk) bus.direct_read_data <= mem[bus.direct_read_address];

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] got [8];
  int n_got, n_done, first_valid, done_cyc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load_image();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'hFF; mem[2] = 8'h00; mem[3] = 8'h17; mem[4] = 8'h60;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] c);
    bus.start         = 1'b1;
    bus.start_address = a;
    bus.instr_count   = c;
    step();
    bus.start = 1'b0;
  endtask

  // Collects accepted instructions until done; optionally stalls the first one.
  task automatic run_xfer(input int hold, input logic [11:0] hold_instr);
    int held = 0;
    bit saw  = 1'b0;
    n_got = 0; n_done = 0; first_valid = 0; done_cyc = 0;
    bus.instr_ready = (hold == 0);
    for (int cyc = 1; cyc <= 300 && n_done == 0; cyc++) begin
      step();
      bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.instr_valid && !saw) begin
        saw = 1'b1;
        first_valid = cyc;
      end
      if (saw && held < hold) begin
        check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("hold_instr", 32'(bus.instr), 32'(hold_instr));
        held++;
      end else if (bus.instr_valid) begin
        bus.instr_ready = 1'b1;
        if (n_got < 8) got[n_got] = bus.instr;
        n_got++;
      end
    end
    check_eq("done_seen", 32'(n_done), 32'd1);
    step();
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
    check_eq("busy_after", 32'(bus.busy), 32'd0);
    bus.instr_ready = 1'b0;
  endtask

  task automatic check_image_seq(input string tag);
    check_eq({tag, "_count"}, 32'(n_got), 32'd3);
    check_eq({tag, "_i0"}, 32'(got[0]), 32'h1FF);
    check_eq({tag, "_i1"}, 32'(got[1]), 32'h017);
    check_eq({tag, "_i2"}, 32'(got[2]), 32'h600);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    bus.start = 1'b0; bus.start_address = '0; bus.instr_count = '0; bus.instr_ready = 1'b0;
    clear_mem();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #1;
    check_eq("rst_addr",  32'(bus.direct_read_address), 32'd0);
    check_eq("rst_instr", 32'(bus.instr), 32'd0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_busy",  32'(bus.busy), 32'd0);
    check_eq("rst_done",  32'(bus.done), 32'd0);
    check_eq("rst_err",   32'(bus.err), 32'd0);
    step(); step();
    resetN = 1'b1;
    step();

    // Three instructions, consumer always ready; a stray start while busy is ignored.
    load_image();
    do_start(8'h00, 8'd3);
    check_eq("t1_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1; bus.start_address = 8'h80; bus.instr_count = 8'd1;
    run_xfer(0, 12'h000);
    check_eq("t1_latency2", 32'(first_valid), 32'd5);
    check_eq("t1_done_cyc", 32'(done_cyc), 32'd16);
    check_image_seq("t1");

    // Consumer stalls the first instruction for four cycles.
    do_start(8'h00, 8'd3);
    run_xfer(4, 12'h1FF);
    check_eq("t2_latency2", 32'(first_valid), 32'd5);
    check_eq("t2_done_cyc", 32'(done_cyc), 32'd20);
    check_image_seq("t2");

    // Pointer wraps from FF to 00 between opcode and operand.
    clear_mem();
    mem[8'hFF] = 8'h20; mem[8'h00] = 8'h0C;
    do_start(8'hFF, 8'd1);
    check_eq("t3_addr_ff", 32'(bus.direct_read_address), 32'hFF);
    step(); step();
    check_eq("t3_addr_00", 32'(bus.direct_read_address), 32'h00);
    run_xfer(0, 12'h000);
    check_eq("t3_count", 32'(n_got), 32'd1);
    check_eq("t3_instr", 32'(got[0]), 32'h20C);
    check_eq("t3_ptr_end", 32'(bus.direct_read_address), 32'h01);

    // Zero count: immediate done, no memory access.
    do_start(8'h40, 8'd0);
    check_eq("t4_done", 32'(bus.done), 32'd1);
    check_eq("t4_busy", 32'(bus.busy), 32'd1);
    check_eq("t4_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("t4_addr", 32'(bus.direct_read_address), 32'h01);
    step();
    check_eq("t4_done_end", 32'(bus.done), 32'd0);
    check_eq("t4_busy_end", 32'(bus.busy), 32'd0);
    check_eq("t4_addr_end", 32'(bus.direct_read_address), 32'h01);

    // Asynchronous reset while waiting for the operand byte.
    load_image();
    do_start(8'h00, 8'd3);
    step(); step();
    check_eq("t5_pre_busy", 32'(bus.busy), 32'd1);
    check_eq("t5_pre_addr", 32'(bus.direct_read_address), 32'h01);
    #1 resetN = 1'b0;
    #1;
    check_eq("t5_addr",  32'(bus.direct_read_address), 32'd0);
    check_eq("t5_instr", 32'(bus.instr), 32'd0);
    check_eq("t5_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("t5_busy",  32'(bus.busy), 32'd0);
    check_eq("t5_done",  32'(bus.done), 32'd0);
    check_eq("t5_err",   32'(bus.err), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done || bus.busy) hi_cnt++;
    end
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done || bus.busy) hi_cnt++;
    end
    check_eq("t5_quiet", 32'(hi_cnt), 32'd0);
    do_start(8'h00, 8'd3);
    run_xfer(0, 12'h000);
    check_eq("t5_latency2", 32'(first_valid), 32'd5);
    check_image_seq("t5");

    // Opcode byte with nonzero low nibble.
    clear_mem();
    mem[0] = 8'h13; mem[1] = 8'hFF;
    do_start(8'h00, 8'd1);
    run_xfer(0, 12'h000);
`ifdef INSTR_READER_FORMAT_CHECK_EN
    check_eq("t6_no_valid", 32'(n_got), 32'd0);
    check_eq("t6_done_cyc", 32'(done_cyc), 32'd2);
    check_eq("t6_err", 32'(bus.err), 32'd1);
    do_start(8'h00, 8'd0);
    check_eq("t6_err_clr", 32'(bus.err), 32'd0);
    step();
`else
    check_eq("t6_count", 32'(n_got), 32'd1);
    check_eq("t6_instr", 32'(got[0]), 32'h1FF);
    check_eq("t6_err", 32'(bus.err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
